fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch buffer between instruction memory and `decode`. It requests 4-byte words from memory ahead of execution and holds them in a byte-granular circular queue. It presents the next 4 instruction bytes, aligned to the current instruction start, as `ope`. When decode reports the instruction length (`num_of_ope`, 1–4 bytes), it retires exactly that many bytes. A control-transfer redirect flushes the queue and restarts fetching at the target EIP.

## Interface
Parameters:
- `DEPTH`, 8: queue capacity in bytes; power of two, at least 8.
- `RESET_EIP`, 32'h0000_0000: fetch address loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `mem_req`, output, 1: one-cycle read request pulse.
- `mem_addr`, output, 32: byte address of the request; valid while `mem_req` is high.
- `mem_valid`, input, 1: read data is valid this cycle.
- `mem_data`, input, 32: bytes `mem_addr+0..+3`; `[31:24]` is the lowest address.
- `ope`, output, 32: head bytes. `[31:24]` is the opcode byte at `ope_eip`.
- `ope_valid`, output, 1: queue holds at least 4 bytes.
- `ope_eip`, output, 32: address of the `ope[31:24]` byte.
- `take`, input, 1: retire `num_of_ope` bytes.
- `num_of_ope`, input, 4: instruction length; legal values are 1–4.
- `redirect`, input, 1: flush and refetch from `redirect_eip`.
- `redirect_eip`, input, 32: new fetch target.
- `err`, output, 1: sticky illegal-take flag.

## Operation
State machine:
- `IDLE`: no request outstanding. Move to `WAIT` when a request is issued.
- `WAIT`: one request outstanding.
  - Response arrives: write 4 bytes, add 4 to `count`, advance `fetch_addr` by 4, go to `IDLE`.
  - `redirect` arrives instead: go to `WAIT_DROP`.
- `WAIT_DROP`: a response is still in flight but stale.
  - Response arrives: discard it, go to `IDLE`.
  - A further `redirect`: stay in `WAIT_DROP`.

Request rule:
- In `IDLE`, with `DEPTH - count >= 4` and no `redirect` this cycle, drive `mem_req`=1 and `mem_addr`=`fetch_addr`.
- At most one request is outstanding at any time.

Take rule:
- A take is legal when `take`=1, `ope_valid`=1, and 1 ≤ `num_of_ope` ≤ 4.
- Legal take: head advances by n, `count` decreases by n, `ope_eip` increases by n.
- Illegal take: no state change; `err` is set and held until reset.
- `take` with `ope_valid`=0 sets `err`.

Redirect rule, highest priority:
- `count` becomes 0 and head/tail pointers become 0.
- `fetch_addr` and `ope_eip` load `redirect_eip`.
- A `take` in the same cycle is ignored and does not set `err`.
- A `mem_valid` in the same cycle is discarded.

Width and wrap-around rules:
- Pointers are log2(DEPTH) bits and wrap modulo `DEPTH`.
- `count` is log2(DEPTH)+1 bits.
- Addresses wrap modulo 2^32.

Boundary cases:
- Response and legal take in the same cycle: `count` = `count` + 4 − n. Both pointers update.
- Queue full (`count`=`DEPTH`): no request is issued. `mem_valid` can only occur in `WAIT`/`WAIT_DROP`, so overflow is impossible by construction.
- `mem_valid` while in `IDLE` is ignored.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `ope`=0, `ope_valid`=0, `ope_eip`=`RESET_EIP`, `err`=0, state=`IDLE`, `count`=0.
- `mem_req` and `mem_addr` are registered. The first request appears in the first cycle after the first rising edge with `reset`=0.
- Memory response latency is 1 or more cycles after `mem_req`.
- Response to `ope`: bytes written on edge k are visible on `ope`/`ope_valid` after edge k, with no combinational path from `mem_data`.
- `ope`, `ope_valid` and `ope_eip` reflect a take or redirect on the next cycle.
- Steady state with 1-cycle memory: one request every 2 cycles, giving 2 bytes per cycle.
- Reset asserted mid-request: the outstanding response is forgotten, so a late `mem_valid` lands in `IDLE` and is ignored.

## Configuration
- `FETCH_QUEUE_PERF_EN` defined: adds output `flush_cnt` [15:0] and output `stall_cnt` [15:0].
  - `flush_cnt` counts redirects.
  - `stall_cnt` counts cycles with `ope_valid`=0 and no `redirect`.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `fetch_queue_pkg`:
  - `BYTE_W`=8
  - `WORD_BYTES`=4
  - `MAX_OPE_LEN`=4
  - state enum `fq_state_t` {`IDLE`, `WAIT`, `WAIT_DROP`}
- Sub-module `fetch_queue_ring`: byte storage with write port (4 bytes at tail) and read port (4 bytes at head). It owns the head, tail and count arithmetic.
- The top level holds the FSM, `fetch_addr`, `ope_eip`, the `err` flag and the optional counters.

## Test plan
- Reset release with `RESET_EIP`=0 and 1-cycle memory returning 32'hB802_0000 → `mem_req` at address 0, then 4. `ope`=32'hB802_0000 with `ope_valid`=1 and `ope_eip`=0.
- Byte-granular retire: queue holds 55 89 E5 B8 | 02 00 00 00. Take `num_of_ope`=1, then 2 → `ope`=32'h89E5_B802 with `ope_eip`=1, then `ope`=32'hB802_0000 with `ope_eip`=3. Wrap-around exercised over 10 sequential words.
- Queue full with DEPTH=8 and no takes → exactly 2 requests, then `mem_req` stays 0 and `count`=8. One take of 4 → next request issued in `IDLE`.
- Redirect to 32'h0000_0040 while in `WAIT` → that response is dropped, `ope_valid`=0, and the next `mem_addr`=32'h40. The first valid `ope` comes from address 0x40 with `ope_eip`=32'h40.
- Illegal takes: `num_of_ope`=5 with `ope_valid`=1, and `take` with `ope_valid`=0 → `err`=1 and sticky, `ope_eip` unchanged. A simultaneous take and redirect does not set `err`.
- Response and take of 3 in the same cycle with `count`=4 → `count`=5. With `FETCH_QUEUE_PERF_EN` defined, 3 redirects give `flush_cnt`=3.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Used by fetch_queue (optional FETCH_QUEUE_PERF_EN) and fetch_queue_ring.
package fetch_queue_pkg;
    localparam int BYTE_W      = 8;
    localparam int WORD_BYTES  = 4;
    localparam int MAX_OPE_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WAIT_DROP
    } fq_state_t;

    function automatic logic len_ok(input logic [3:0] n);
        return (n >= 4'd1) && (n <= 4'(MAX_OPE_LEN));
    endfunction
endpackage

// File: rtl/fetch_queue_ring.sv
// Byte-granular circular buffer: 4-byte write at tail, 4-byte read at head.
// Owns head/tail pointers and the fill count.
module fetch_queue_ring
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WORD_BYTES*BYTE_W-1:0] wr_data,
    input  logic                         rd_en,
    input  logic [2:0]                   rd_n,
    output logic [WORD_BYTES*BYTE_W-1:0] rd_data,
    output logic [PW:0]                  count
);
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   add_n;
    logic [PW:0]   sub_n;

    assign add_n = wr_en ? (PW+1)'(WORD_BYTES) : '0;
    assign sub_n = rd_en ? (PW+1)'(rd_n) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    mem_q[tail + PW'(i)] <=
                        wr_data[(WORD_BYTES-1-i)*BYTE_W +: BYTE_W];
                end
                tail <= tail + PW'(WORD_BYTES);
            end
            if (rd_en) begin
                head <= head + PW'(rd_n);
            end
            count <= count + add_n - sub_n;
        end
    end

    // Lowest address lands in the most significant byte.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_data[(WORD_BYTES-1-i)*BYTE_W +: BYTE_W] = mem_q[head + PW'(i)];
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetch FSM, EIP tracking, sticky error.
// Define FETCH_QUEUE_PERF_EN to add flush_cnt/stall_cnt counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic [31:0] ope,
    output logic        ope_valid,
    output logic [31:0] ope_eip,
    input  logic        take,
    input  logic [3:0]  num_of_ope,
    input  logic        redirect,
    input  logic [31:0] redirect_eip,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [15:0] flush_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic        err
);
    localparam int PW = $clog2(DEPTH);

    fq_state_t   state;
    fq_state_t   state_nxt;
    logic [PW:0] count;
    logic [31:0] fetch_addr;
    logic        issue;
    logic        wr_en;
    logic        take_ok;
    logic        take_bad;

    assign ope_valid = count >= (PW+1)'(WORD_BYTES);
    assign take_ok   = take && !redirect && ope_valid && len_ok(num_of_ope);
    assign take_bad  = take && !redirect && !take_ok;
    assign wr_en     = (state == WAIT) && mem_valid && !redirect;

    // A response coinciding with a redirect is consumed and discarded.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!redirect && count <= (PW+1)'(DEPTH - WORD_BYTES)) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) state_nxt = IDLE;
                else if (redirect) state_nxt = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (mem_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fetch_addr <= RESET_EIP;
            ope_eip    <= RESET_EIP;
            err        <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_req <= issue;
            if (issue) mem_addr <= fetch_addr;
            if (redirect) begin
                fetch_addr <= redirect_eip;
                ope_eip    <= redirect_eip;
            end else begin
                if (wr_en) fetch_addr <= fetch_addr + 32'd4;
                if (take_ok) ope_eip <= ope_eip + 32'(num_of_ope);
            end
            if (take_bad) err <= 1'b1;
        end
    end

    fetch_queue_ring #(.DEPTH(DEPTH)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (wr_en),
        .wr_data (mem_data),
        .rd_en   (take_ok),
        .rd_n    (num_of_ope[2:0]),
        .rd_data (ope),
        .count   (count)
    );

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (redirect && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
            if (!ope_valid && !redirect && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=8, RESET_EIP=0).
// Memory model serves img[] with configurable response latency.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] ope;
    logic        ope_valid;
    logic [31:0] ope_eip;
    logic        take = 1'b0;
    logic [3:0]  num_of_ope = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_eip = '0;
    logic        err;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 0;
    int inject_req = 0;
    int inject_ack = 0;
    int resp_cnt = 0;
    logic [31:0] resp_addr = '0;
    logic [7:0] img [256];

    typedef struct {
        logic [31:0] eip;
        logic [31:0] ope;
        logic [3:0]  n;
    } vec_t;
    vec_t vecs [12];

    fetch_queue #(.DEPTH(8), .RESET_EIP(32'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .ope          (ope),
        .ope_valid    (ope_valid),
        .ope_eip      (ope_eip),
        .take         (take),
        .num_of_ope   (num_of_ope),
        .redirect     (redirect),
        .redirect_eip (redirect_eip),
`ifdef FETCH_QUEUE_PERF_EN
        .flush_cnt    (flush_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] img_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {img[b], img[8'(b + 8'd1)], img[8'(b + 8'd2)], img[8'(b + 8'd3)]};
    endfunction

    always @(posedge clk) begin
        #1;
        mem_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = img_word(resp_addr);
            end
        end
        if (mem_req) begin
            if (mem_lat == 0) begin
                mem_valid = 1'b1;
                mem_data  = img_word(mem_addr);
            end else begin
                resp_cnt  = mem_lat;
                resp_addr = mem_addr;
            end
        end
        if (inject_req != inject_ack) begin
            inject_ack = inject_req;
            mem_valid  = 1'b1;
            mem_data   = 32'hDEAD_BEEF;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ope(input string nm);
        int k = 0;
        while (ope_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({nm, "_timeout"}, 32'(ope_valid), 32'd1);
    endtask

    task automatic wait_req(input string nm);
        int k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({nm, "_timeout"}, 32'(mem_req), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        take = 1'b0;
        redirect = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int nreq;
        int first_req;
        logic [31:0] addrs [2];

        for (int i = 0; i < 256; i++) img[i] = 8'(i);
        img[0] = 8'hB8; img[1] = 8'h02; img[2] = 8'h00; img[3] = 8'h00;
        img[16] = 8'h55; img[17] = 8'h89; img[18] = 8'hE5; img[19] = 8'hB8;
        img[20] = 8'h02; img[21] = 8'h00; img[22] = 8'h00; img[23] = 8'h00;

        vecs[0]  = '{32'h10, 32'h5589E5B8, 4'd1};
        vecs[1]  = '{32'h11, 32'h89E5B802, 4'd2};
        vecs[2]  = '{32'h13, 32'hB8020000, 4'd4};
        vecs[3]  = '{32'h17, 32'h0018191A, 4'd3};
        vecs[4]  = '{32'h1A, 32'h1A1B1C1D, 4'd4};
        vecs[5]  = '{32'h1E, 32'h1E1F2021, 4'd1};
        vecs[6]  = '{32'h1F, 32'h1F202122, 4'd2};
        vecs[7]  = '{32'h21, 32'h21222324, 4'd4};
        vecs[8]  = '{32'h25, 32'h25262728, 4'd3};
        vecs[9]  = '{32'h28, 32'h28292A2B, 4'd4};
        vecs[10] = '{32'h2C, 32'h2C2D2E2F, 4'd4};
        vecs[11] = '{32'h30, 32'h30313233, 4'd0};

        // Reset state
        do_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ope", ope, 32'd0);
        chk("rst_ope_valid", 32'(ope_valid), 32'd0);
        chk("rst_ope_eip", ope_eip, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // First fetches, then fill to DEPTH with no takes
        reset = 1'b0;
        nreq = 0;
        first_req = -1;
        addrs[0] = 'x;
        addrs[1] = 'x;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_req === 1'b1) begin
                if (first_req < 0) first_req = c;
                if (nreq < 2) addrs[nreq] = mem_addr;
                nreq++;
            end
        end
        chk("first_req_cycle", 32'(first_req), 32'd1);
        chk("full_nreq", 32'(nreq), 32'd2);
        chk("req0_addr", addrs[0], 32'h0);
        chk("req1_addr", addrs[1], 32'h4);
        chk("full_count", 32'(dut.count), 32'd8);
        chk("first_ope", ope, 32'hB802_0000);
        chk("first_valid", 32'(ope_valid), 32'd1);
        chk("first_eip", ope_eip, 32'h0);

        // Stray response while IDLE and full
        inject_req++;
        tick();
        tick();
        chk("idle_valid_count", 32'(dut.count), 32'd8);
        chk("idle_valid_ope", ope, 32'hB802_0000);

        // Take 4 reopens space; next request goes out from IDLE
        mem_lat = 2;
        take = 1'b1;
        num_of_ope = 4'd4;
        tick();
        take = 1'b0;
        chk("take4_eip", ope_eip, 32'h4);
        chk("take4_ope", ope, 32'h0405_0607);
        chk("take4_count", 32'(dut.count), 32'd4);
        tick();
        chk("refill_req", 32'(mem_req), 32'd1);
        chk("refill_addr", mem_addr, 32'h8);

        // Redirect while WAIT, with a simultaneous illegal take
        redirect = 1'b1;
        redirect_eip = 32'h40;
        take = 1'b1;
        num_of_ope = 4'd5;
        tick();
        redirect = 1'b0;
        take = 1'b0;
        chk("redir_valid", 32'(ope_valid), 32'd0);
        chk("redir_eip", ope_eip, 32'h40);
        chk("redir_err", 32'(err), 32'd0);
        wait_req("redir_req");
        chk("redir_addr", mem_addr, 32'h40);
        wait_ope("redir_ope");
        chk("redir_ope", ope, 32'h4041_4243);
        chk("redir_ope_eip", ope_eip, 32'h40);

        // Illegal length sets a sticky error
        take = 1'b1;
        num_of_ope = 4'd5;
        tick();
        take = 1'b0;
        chk("len5_err", 32'(err), 32'd1);
        chk("len5_eip", ope_eip, 32'h40);
        repeat (3) tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Take with no valid ope
        do_reset();
        chk("err_cleared", 32'(err), 32'd0);
        reset = 1'b0;
        take = 1'b1;
        num_of_ope = 4'd1;
        tick();
        take = 1'b0;
        chk("empty_take_err", 32'(err), 32'd1);
        chk("empty_take_eip", ope_eip, 32'h0);

        // Response and take of 3 in the same cycle at count 4
        do_reset();
        mem_lat = 0;
        reset = 1'b0;
        repeat (3) tick();
        chk("pre_both_count", 32'(dut.count), 32'd4);
        take = 1'b1;
        num_of_ope = 4'd3;
        tick();
        take = 1'b0;
        chk("both_count", 32'(dut.count), 32'd5);
        chk("both_eip", ope_eip, 32'h3);
        chk("both_ope", ope, 32'h0004_0506);

        // Byte-granular retire across many ring wraps
        mem_lat = 1;
        redirect = 1'b1;
        redirect_eip = 32'h10;
        tick();
        redirect = 1'b0;
        for (int v = 0; v < 12; v++) begin
            wait_ope($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_eip", v), ope_eip, vecs[v].eip);
            chk($sformatf("vec%0d_ope", v), ope, vecs[v].ope);
            if (vecs[v].n != 4'd0) begin
                take = 1'b1;
                num_of_ope = vecs[v].n;
                tick();
                take = 1'b0;
            end
        end
        chk("vec_err", 32'(err), 32'd0);

`ifdef FETCH_QUEUE_PERF_EN
        do_reset();
        chk("perf_rst_flush", 32'(flush_cnt), 32'd0);
        chk("perf_rst_stall", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        redirect = 1'b1;
        redirect_eip = 32'h80;
        repeat (3) tick();
        redirect = 1'b0;
        tick();
        chk("perf_flush", 32'(flush_cnt), 32'd3);
        chk("perf_stall", 32'(stall_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
